pulpino_boot_ctrl: RTL and testbench
====================================

Name: pulpino_boot_ctrl

Overview:
- Wishbone-slave control block in the user wrapper that sequences the PULPino core's reset and start-up.
- Drives the core's rst_n and fetch_enable_i from a small register file; firmware on the management SoC controls these registers.
- A programmable reset-hold and boot-delay FSM removes the direct pad-driven fetch_enable.
- Reports state and raises an interrupt once the core is running.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode matches wbs_adr_i[31:8] against BASE_ADDR[31:8].
- CNT_W, 16, width of the reset-hold and boot-delay counters/registers.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- core_rst_n_o  out  1  active-low reset to pulpino_top.
- fetch_enable_o  out  1  fetch_enable_i to pulpino_top.
- irq_o  out  1  level interrupt to the caravel irq[0].
- state_o  out  2  FSM state, for la_data_out debug.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, core_rst_n_o=0, fetch_enable_o=0, irq_o=0, state_o=OFF.
- Register reset values: CTRL=0, RST_CYCLES=16, BOOT_DELAY=8.
- Registers (offset = wbs_adr_i[7:0]):
  - 0x00 CTRL: [0] run_req, [1] soft_rst (write-1 pulse, reads 0), [2] irq_en.
  - 0x04 STATUS (RO except W1C bits): [1:0] state, [2] core_rst_n, [3] fetch_enable, [8] run_entered (sticky, W1C), [9] wdt_fired (sticky, W1C).
  - 0x08 RST_CYCLES, CNT_W bits.
  - 0x0C BOOT_DELAY, CNT_W bits.
  - Unmapped offsets, or addresses outside the base: acked; reads return 0; writes ignored.
- Wishbone handshake:
  - When stb&cyc&!ack, ack=1 on the next edge for exactly one cycle, then 0. Every access has one wait state, so there is no back-to-back ack.
  - Read data is valid in the ack cycle; wbs_dat_o returns to 0 otherwise.
  - Writes update only the bytes selected by wbs_sel_i, at the ack edge.
- FSM states: OFF=0, RST_HOLD=1, BOOT_WAIT=2, RUN=3.
  - OFF: core_rst_n=0, fetch=0. Moves to RST_HOLD when run_req=1; counter is loaded to 0.
  - RST_HOLD: core_rst_n=0. Counts up; moves to BOOT_WAIT when cnt == max(RST_CYCLES,1)-1, i.e. it holds for max(RST_CYCLES,1) cycles.
  - BOOT_WAIT: core_rst_n=1, fetch=0. Stays for max(BOOT_DELAY,1) cycles, then moves to RUN.
  - RUN: core_rst_n=1, fetch=1. Sets run_entered on entry.
- Transition priority, per cycle:
  1. run_req==0 → OFF from any state.
  2. soft_rst pulse → RST_HOLD with counter cleared, from RST_HOLD, BOOT_WAIT or RUN. This restarts the hold if already in RST_HOLD.
  3. Normal count transitions.
- Register writes mid-sequence: writing RST_CYCLES or BOOT_DELAY affects the compare immediately. If the counter is already ≥ the new limit-1, the FSM advances on the next cycle.
- Outputs are registered from the state; the FSM transition edge and the output change occur on the same edge.
- irq_o = irq_en & run_entered. Cleared by writing 1 to STATUS[8]. A set event in the same cycle as a W1C wins: the bit stays set.
- wb_rst_i asserted mid-operation immediately forces all reset values; the core is held in reset.

Optional Feature:
- Macro: PULPINO_BOOT_WDT_EN.
- With the macro defined:
  - 0x10 WDT_LOAD (32-bit, reset 0 = disabled).
  - 0x14 WDT_KICK: any write reloads the watchdog.
  - In RUN with WDT_LOAD≠0, the watchdog counts down from WDT_LOAD each cycle. It is reloaded on entry to RUN and on kick.
  - On reaching 0: FSM → RST_HOLD, wdt_fired=1, irq_o additionally asserted while irq_en & wdt_fired.
- Without the macro: 0x10/0x14 read 0, writes are ignored, and wdt_fired is tied 0.

Test Plan:
- Reset, then read 0x08/0x0C → 16/8; core_rst_n_o=0, fetch_enable_o=0, ack one cycle after each stb.
- Write RST_CYCLES=3, BOOT_DELAY=2, CTRL=1 → core_rst_n_o low for exactly 3 cycles after OFF→RST_HOLD, high 2 cycles with fetch=0, then fetch_enable_o=1 and STATUS reads 0x10F.
- In RUN, write CTRL=0x3 (soft_rst) → the next cycle is RST_HOLD with core_rst_n_o=0, and the sequence replays. Write CTRL=0 in BOOT_WAIT → OFF next cycle.
- Set irq_en, reach RUN → irq_o=1. Write STATUS=0x100 → irq_o=0. Write with sel=4'b0010 to CTRL → CTRL unchanged.
- RST_CYCLES=0, BOOT_DELAY=0 → 1-cycle hold and 1-cycle wait. Unmapped 0x40 read → 0 with ack. Access at base+0x100 → ack, 0.
- (WDT_EN) WDT_LOAD=10, reach RUN, no kick → after 10 cycles state=RST_HOLD, STATUS[9]=1. With a kick every 5 cycles → stays in RUN.

Source files
------------

// File: rtl/pulpino_boot_ctrl.sv
// Wishbone-controlled reset/boot sequencer for the PULPino core.
// Optional watchdog in RUN is enabled by defining PULPINO_BOOT_WDT_EN.
module pulpino_boot_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_rst_n_o,
  output logic        fetch_enable_o,
  output logic        irq_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RST_HOLD  = 2'd1,
    ST_BOOT_WAIT = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam logic [7:0] ADR_CTRL   = 8'h00;
  localparam logic [7:0] ADR_STATUS = 8'h04;
  localparam logic [7:0] ADR_RST    = 8'h08;
  localparam logic [7:0] ADR_BOOT   = 8'h0C;

  localparam logic [CNT_W-1:0] RST_CYCLES_RST = CNT_W'(16);
  localparam logic [CNT_W-1:0] BOOT_DELAY_RST = CNT_W'(8);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rst_cycles_q, rst_cycles_d;
  logic [CNT_W-1:0]   boot_delay_q, boot_delay_d;
  logic [CNT_W-1:0]   rst_last_c, boot_last_c;
  logic               run_req_q, run_req_d;
  logic               irq_en_q, irq_en_d;
  logic               run_entered_q, run_entered_d;
  logic               wdt_fired_q, wdt_fired_d;
  logic               ack_q;
  logic [31:0]        dat_q, dat_d;
  logic               core_rst_n_q, fetch_q, irq_q;

  logic               req_c, hit_c, wr_c, rd_c;
  logic [7:0]         off_c;
  logic [31:0]        ctrl_merge_c, rdata_c;
  logic               soft_rst_c, clr_run_c, clr_wdt_c;
  logic               wdt_expire_c, wdt_fire_c;

  // Every access gets exactly one ack, never back-to-back
  assign req_c = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit_c = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr_c  = req_c & hit_c & wbs_we_i;
  assign rd_c  = req_c & hit_c & ~wbs_we_i;
  assign off_c = wbs_adr_i[7:0];

  always_comb begin
    ctrl_merge_c = byte_merge({29'd0, irq_en_q, 1'b0, run_req_q}, wbs_dat_i, wbs_sel_i);
    run_req_d    = run_req_q;
    irq_en_d     = irq_en_q;
    soft_rst_c   = 1'b0;
    clr_run_c    = 1'b0;
    clr_wdt_c    = 1'b0;
    rst_cycles_d = rst_cycles_q;
    boot_delay_d = boot_delay_q;
    if (wr_c) begin
      case (off_c)
        ADR_CTRL: begin
          run_req_d  = ctrl_merge_c[0];
          soft_rst_c = ctrl_merge_c[1];
          irq_en_d   = ctrl_merge_c[2];
        end
        ADR_STATUS: begin
          clr_run_c = wbs_sel_i[1] & wbs_dat_i[8];
          clr_wdt_c = wbs_sel_i[1] & wbs_dat_i[9];
        end
        ADR_RST:  rst_cycles_d = CNT_W'(byte_merge(32'(rst_cycles_q), wbs_dat_i, wbs_sel_i));
        ADR_BOOT: boot_delay_d = CNT_W'(byte_merge(32'(boot_delay_q), wbs_dat_i, wbs_sel_i));
        default: ;
      endcase
    end
  end

`ifdef PULPINO_BOOT_WDT_EN
  localparam logic [7:0] ADR_WDT_LOAD = 8'h10;
  localparam logic [7:0] ADR_WDT_KICK = 8'h14;

  logic [31:0] wdt_load_q, wdt_load_d, wdt_cnt_q, wdt_cnt_d;
  logic        kick_c;

  assign kick_c = wr_c && (off_c == ADR_WDT_KICK);

  // Counter tracks the load value outside RUN, so entry to RUN starts a full period
  always_comb begin
    wdt_load_d = wdt_load_q;
    if (wr_c && (off_c == ADR_WDT_LOAD)) wdt_load_d = byte_merge(wdt_load_q, wbs_dat_i, wbs_sel_i);
    wdt_cnt_d = wdt_cnt_q - 32'd1;
    if ((wdt_load_q == 32'd0) || kick_c || (state_q != ST_RUN)) wdt_cnt_d = wdt_load_d;
  end

  assign wdt_expire_c = (state_q == ST_RUN) && (wdt_load_q != 32'd0) && !kick_c &&
                        (wdt_cnt_q <= 32'd1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wdt_load_q <= 32'd0;
      wdt_cnt_q  <= 32'd0;
    end else begin
      wdt_load_q <= wdt_load_d;
      wdt_cnt_q  <= wdt_cnt_d;
    end
  end
`else
  assign wdt_expire_c = 1'b0;
`endif

  always_comb begin
    rdata_c = 32'd0;
    case (off_c)
      ADR_CTRL:   rdata_c = {29'd0, irq_en_q, 1'b0, run_req_q};
      ADR_STATUS: rdata_c = {22'd0, wdt_fired_q, run_entered_q, 4'd0,
                             fetch_q, core_rst_n_q, 2'(state_q)};
      ADR_RST:    rdata_c = 32'(rst_cycles_q);
      ADR_BOOT:   rdata_c = 32'(boot_delay_q);
`ifdef PULPINO_BOOT_WDT_EN
      ADR_WDT_LOAD: rdata_c = wdt_load_q;
`endif
      default:    rdata_c = 32'd0;
    endcase
    dat_d = rd_c ? rdata_c : 32'd0;
  end

  // A zero limit behaves as one cycle
  assign rst_last_c  = (rst_cycles_q == '0) ? '0 : rst_cycles_q - CNT_W'(1);
  assign boot_last_c = (boot_delay_q == '0) ? '0 : boot_delay_q - CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdt_fire_c = 1'b0;
    if (!run_req_d) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else if (soft_rst_c && (state_q != ST_OFF)) begin
      state_d = ST_RST_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_RST_HOLD;
          cnt_d   = '0;
        end
        ST_RST_HOLD: begin
          if (cnt_q >= rst_last_c) begin
            state_d = ST_BOOT_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BOOT_WAIT: begin
          if (cnt_q >= boot_last_c) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (wdt_expire_c) begin
            state_d    = ST_RST_HOLD;
            cnt_d      = '0;
            wdt_fire_c = 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Set events win over a same-cycle W1C
  assign run_entered_d = (run_entered_q & ~clr_run_c) | ((state_d == ST_RUN) && (state_q != ST_RUN));
  assign wdt_fired_d   = (wdt_fired_q & ~clr_wdt_c) | wdt_fire_c;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_OFF;
      cnt_q         <= '0;
      rst_cycles_q  <= RST_CYCLES_RST;
      boot_delay_q  <= BOOT_DELAY_RST;
      run_req_q     <= 1'b0;
      irq_en_q      <= 1'b0;
      run_entered_q <= 1'b0;
      wdt_fired_q   <= 1'b0;
      ack_q         <= 1'b0;
      dat_q         <= 32'd0;
      core_rst_n_q  <= 1'b0;
      fetch_q       <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rst_cycles_q  <= rst_cycles_d;
      boot_delay_q  <= boot_delay_d;
      run_req_q     <= run_req_d;
      irq_en_q      <= irq_en_d;
      run_entered_q <= run_entered_d;
      wdt_fired_q   <= wdt_fired_d;
      ack_q         <= req_c;
      dat_q         <= dat_d;
      core_rst_n_q  <= (state_d == ST_BOOT_WAIT) || (state_d == ST_RUN);
      fetch_q       <= (state_d == ST_RUN);
      irq_q         <= irq_en_d & (run_entered_d | wdt_fired_d);
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign core_rst_n_o   = core_rst_n_q;
  assign fetch_enable_o = fetch_q;
  assign irq_o          = irq_q;
  assign state_o        = 2'(state_q);

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// Directed bench for pulpino_boot_ctrl: register vectors plus boot-sequence scenarios.
module tb_pulpino_boot_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_rst_n_o, fetch_enable_o, irq_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  pulpino_boot_ctrl #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_rst_n_o(core_rst_n_o), .fetch_enable_o(fetch_enable_o),
    .irq_o(irq_o), .state_o(state_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // One Wishbone access; ack must appear on the first edge after the request
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rdata);
    if (wbs_ack_o) tick();
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    tick();
    chk("ack", 32'(wbs_ack_o), 32'd1);
    rdata = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat);
    logic [31:0] unused;
    wb_xfer(1'b1, BASE | 32'(off), 4'hF, dat, unused);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] dat);
    wb_xfer(1'b0, BASE | 32'(off), 4'hF, 32'd0, dat);
  endtask

  // Called in the first cycle of RST_HOLD; walks hold, boot wait and RUN entry
  task automatic check_seq(input int hold, input int boot);
    for (int i = 0; i < hold; i++) begin
      chk("hold_state", 32'(state_o), 32'd1);
      chk("hold_rstn", 32'(core_rst_n_o), 32'd0);
      chk("hold_fetch", 32'(fetch_enable_o), 32'd0);
      tick();
    end
    for (int i = 0; i < boot; i++) begin
      chk("boot_state", 32'(state_o), 32'd2);
      chk("boot_rstn", 32'(core_rst_n_o), 32'd1);
      chk("boot_fetch", 32'(fetch_enable_o), 32'd0);
      tick();
    end
    chk("run_state", 32'(state_o), 32'd3);
    chk("run_rstn", 32'(core_rst_n_o), 32'd1);
    chk("run_fetch", 32'(fetch_enable_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    vecs[0]  = '{1'b0, BASE | 32'h08, 4'hF, 32'd0, 32'd16};
    vecs[1]  = '{1'b0, BASE | 32'h0C, 4'hF, 32'd0, 32'd8};
    vecs[2]  = '{1'b0, BASE | 32'h00, 4'hF, 32'd0, 32'd0};
    vecs[3]  = '{1'b0, BASE | 32'h04, 4'hF, 32'd0, 32'd0};
    vecs[4]  = '{1'b0, BASE | 32'h10, 4'hF, 32'd0, 32'd0};
    vecs[5]  = '{1'b0, BASE | 32'h14, 4'hF, 32'd0, 32'd0};
    vecs[6]  = '{1'b0, BASE | 32'h40, 4'hF, 32'd0, 32'd0};
    vecs[7]  = '{1'b0, BASE + 32'h100, 4'hF, 32'd0, 32'd0};
    vecs[8]  = '{1'b1, BASE | 32'h08, 4'hF, 32'hFFFF_0003, 32'd0};
    vecs[9]  = '{1'b0, BASE | 32'h08, 4'hF, 32'd0, 32'd3};
    vecs[10] = '{1'b1, BASE | 32'h0C, 4'b0010, 32'h0000_AB02, 32'd0};
    vecs[11] = '{1'b0, BASE | 32'h0C, 4'hF, 32'd0, 32'h0000_AB08};
    vecs[12] = '{1'b1, BASE | 32'h0C, 4'b0001, 32'h1234_5602, 32'd0};
    vecs[13] = '{1'b0, BASE | 32'h0C, 4'hF, 32'd0, 32'h0000_AB02};
    vecs[14] = '{1'b1, BASE | 32'h0C, 4'hF, 32'd2, 32'd0};
    vecs[15] = '{1'b0, BASE | 32'h0C, 4'hF, 32'd0, 32'd2};
    vecs[16] = '{1'b1, BASE + 32'h108, 4'hF, 32'd7, 32'd0};
    vecs[17] = '{1'b0, BASE | 32'h08, 4'hF, 32'd0, 32'd3};

    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_rstn", 32'(core_rst_n_o), 32'd0);
    chk("rst_fetch", 32'(fetch_enable_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, r);
      chk($sformatf("vec%0d_dat", i), r, vecs[i].exp);
      tick();
      chk($sformatf("vec%0d_ack_drop", i), 32'(wbs_ack_o), 32'd0);
      chk($sformatf("vec%0d_dat_idle", i), wbs_dat_o, 32'd0);
    end

    // RST_CYCLES=3, BOOT_DELAY=2: start the core
    wr(8'h00, 32'h1);
    check_seq(3, 2);
    chk("run_irq_off", 32'(irq_o), 32'd0);
    rd(8'h04, r);
    chk("status_run", r, 32'h10F);

    // Soft reset from RUN replays the sequence
    wr(8'h00, 32'h3);
    check_seq(3, 2);
    rd(8'h00, r);
    chk("ctrl_soft_reads0", r, 32'h1);

    // Drop run_req during BOOT_WAIT
    wr(8'h00, 32'h3);
    tick(); tick(); tick();
    chk("bw_before_off", 32'(state_o), 32'd2);
    wr(8'h00, 32'h0);
    chk("off_state", 32'(state_o), 32'd0);
    chk("off_rstn", 32'(core_rst_n_o), 32'd0);

    // Interrupt on RUN entry and W1C clear
    wr(8'h04, 32'h100);
    wr(8'h00, 32'h5);
    chk("irq_hold", 32'(irq_o), 32'd0);
    check_seq(3, 2);
    chk("irq_run", 32'(irq_o), 32'd1);
    wb_xfer(1'b1, BASE | 32'h04, 4'b0010, 32'h100, r);
    chk("irq_cleared", 32'(irq_o), 32'd0);
    rd(8'h04, r);
    chk("status_cleared", r, 32'h00F);
    wb_xfer(1'b1, BASE | 32'h00, 4'b0010, 32'h0, r);
    rd(8'h00, r);
    chk("ctrl_sel_unchanged", r, 32'h5);
    chk("ctrl_sel_state", 32'(state_o), 32'd3);

    // Zero limits behave as one cycle each
    wr(8'h00, 32'h0);
    wr(8'h08, 32'h0);
    wr(8'h0C, 32'h0);
    wr(8'h00, 32'h1);
    check_seq(1, 1);
    rd(8'h08, r);
    chk("rst_cycles_zero", r, 32'd0);

`ifdef PULPINO_BOOT_WDT_EN
    // Watchdog without kicks pulls the core back into reset
    wr(8'h00, 32'h0);
    wr(8'h08, 32'd3);
    wr(8'h0C, 32'd2);
    wr(8'h10, 32'd10);
    wr(8'h00, 32'h1);
    check_seq(3, 2);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("wdt_still_run", 32'(state_o), 32'd3);
    end
    tick();
    chk("wdt_fired_state", 32'(state_o), 32'd1);
    rd(8'h04, r);
    chk("wdt_fired_bit", 32'(r[9]), 32'd1);
    wr(8'h00, 32'h0);
    wr(8'h04, 32'h200);
    wr(8'h00, 32'h1);
    check_seq(3, 2);
    for (int i = 0; i < 6; i++) begin
      repeat (4) tick();
      wr(8'h14, 32'h0);
      chk("wdt_kicked_run", 32'(state_o), 32'd3);
    end
    rd(8'h04, r);
    chk("wdt_not_fired", 32'(r[9]), 32'd0);
    wr(8'h10, 32'd0);
`endif

    // Asynchronous reset mid-operation
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_rstn", 32'(core_rst_n_o), 32'd0);
    chk("async_fetch", 32'(fetch_enable_o), 32'd0);
    tick();
    wb_rst_i = 1'b0;
    rd(8'h08, r);
    chk("async_rst_cycles", r, 32'd16);
    rd(8'h00, r);
    chk("async_ctrl", r, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
